// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - active-low 7-segment literals {dp,g,f,e,d,c,b,a} and BCD decode
package disp_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // OR-ing this in turns the decimal point off (segments are active-low)
   localparam logic [7:0] DP_OFF    = 8'h80;

   // Non-BCD nibbles show as a dark digit rather than a misleading glyph
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - DIGITS-wide BCD event counter with sticky overflow (COUNT_SATURATE_EN: hold at all nines instead of wrapping)
module bcd_counter #(
   parameter int DIGITS = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Clear,
   input  logic                inc,
   output logic [4*DIGITS-1:0] count_bcd,
   output logic                overflow
);

   logic [4*DIGITS-1:0] count_inc;
   logic                carry;
   logic                all_nines;

   // Ripple BCD increment; a carry out of the top digit means every digit was 9
   always_comb begin
      count_inc = count_bcd;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count_bcd[4*i +: 4] == 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      all_nines = carry;
   end

   // Count register: Reset over Clear over increment; Clear swallows a same-cycle event
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_bcd <= '0;
         overflow  <= 1'b0;
      end else if (Clear) begin
         count_bcd <= '0;
         overflow  <= 1'b0;
      end else if (inc) begin
         if (all_nines) begin
            overflow  <= 1'b1;
`ifdef COUNT_SATURATE_EN
            count_bcd <= count_bcd;
`else
            count_bcd <= '0;
`endif
         end else begin
            count_bcd <= count_inc;
         end
      end
   end

endmodule

// File: rtl/detect_count_display.sv
// rtl/detect_count_display.sv - counts rising edges of y and scans the BCD count onto a multiplexed 7-segment display (COUNT_SATURATE_EN passed to bcd_counter)
module detect_count_display
   import disp_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                y,
   input  logic                Clear,
   output logic [4*DIGITS-1:0] count_bcd,
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   an,
   output logic                overflow
);

   localparam int               SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int               REF_W    = $clog2(REFRESH_DIV);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_RESET = ~DIGITS'(1);

   logic              y_prev;
   logic              event_y;
   logic [REF_W-1:0]  refresh_cnt;
   logic [SEL_W-1:0]  digit_sel;
   logic [SEL_W-1:0]  sel_next;
   logic [3:0]        nib;
   logic [DIGITS-1:0] an_next;

   assign event_y = y & ~y_prev;

   // y_prev resets high so a y held high through reset release is not an edge
   always_ff @(posedge Clock) begin
      if (Reset) y_prev <= 1'b1;
      else       y_prev <= y;
   end

   bcd_counter #(.DIGITS(DIGITS)) u_counter (
      .Clock     (Clock),
      .Reset     (Reset),
      .Clear     (Clear),
      .inc       (event_y),
      .count_bcd (count_bcd),
      .overflow  (overflow)
   );

   // Digit advance happens on the refresh wrap
   always_comb begin
      sel_next = digit_sel;
      if (refresh_cnt == REF_LAST)
         sel_next = (digit_sel == SEL_LAST) ? '0 : digit_sel + 1'b1;
   end

   // Scan position; Clear deliberately leaves it alone
   always_ff @(posedge Clock) begin
      if (Reset) begin
         refresh_cnt <= '0;
         digit_sel   <= '0;
      end else begin
         refresh_cnt <= (refresh_cnt == REF_LAST) ? '0 : refresh_cnt + 1'b1;
         digit_sel   <= sel_next;
      end
   end

   // Select the nibble and anode for the slot being entered, so an tracks digit_sel
   always_comb begin
      nib     = 4'd0;
      an_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (sel_next == SEL_W'(i)) begin
            nib        = count_bcd[4*i +: 4];
            an_next[i] = 1'b0;
         end
      end
   end

   // seg and an share one register stage so they always switch together
   always_ff @(posedge Clock) begin
      if (Reset) begin
         seg <= SEG_0;
         an  <= AN_RESET;
      end else begin
         seg <= bcd_to_seg(nib) | DP_OFF;
         an  <= an_next;
      end
   end

endmodule

// File: tb/tb_detect_count_display.sv
// tb/tb_detect_count_display.sv - self-checking bench for detect_count_display (COUNT_SATURATE_EN selects saturating expectations)
module tb_detect_count_display;

   logic        Clock;
   logic        Reset;
   logic        y;
   logic        Clear;
   logic [15:0] count_bcd;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   logic [16:0] exp_q[$];

   typedef struct {
      bit         do_reset;
      int         pulses;
      int         exp_val;
      bit         exp_ovf;
      bit         chk_disp;
      logic [7:0] exp_seg0;
      logic [7:0] exp_seg1;
   } vec_t;

   vec_t vecs[6];

   detect_count_display #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .y         (y),
      .Clear     (Clear),
      .count_bcd (count_bcd),
      .seg       (seg),
      .an        (an),
      .overflow  (overflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      Reset = 1'b1;
      y     = 1'b0;
      Clear = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic pulses(input int n);
      for (int k = 0; k < n; k++) begin
         y = 1'b1;
         tick();
         y = 1'b0;
         tick();
      end
   endtask

   task automatic check_sb(input string name);
      logic [16:0] e;
      if (exp_q.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_count"}, 32'(count_bcd), 32'(e[15:0]));
         chk({name, "_ovf"}, 32'(overflow), 32'(e[16]));
      end
   endtask

   task automatic wait_an(input logic [3:0] target, input string name);
      int n;
      n = 0;
      while (an !== target && n < 40) begin
         tick();
         n++;
      end
      chk(name, 32'(an), 32'(target));
   endtask

   task automatic measure_hold(input logic [3:0] cur, input string name);
      int n;
      n = 0;
      while (an === cur && n < 20) begin
         tick();
         n++;
      end
      chk(name, n, 4);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5,    5,    1'b0, 1'b1, 8'h92, 8'hC0};
      vecs[1] = '{1'b1, 9,    9,    1'b0, 1'b0, 8'h00, 8'h00};
      vecs[2] = '{1'b0, 1,    10,   1'b0, 1'b1, 8'hC0, 8'hF9};
      vecs[3] = '{1'b1, 9999, 9999, 1'b0, 1'b0, 8'h00, 8'h00};
`ifdef COUNT_SATURATE_EN
      vecs[4] = '{1'b0, 1,    9999, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[5] = '{1'b0, 1,    9999, 1'b1, 1'b0, 8'h00, 8'h00};
`else
      vecs[4] = '{1'b0, 1,    0,    1'b1, 1'b0, 8'h00, 8'h00};
      vecs[5] = '{1'b0, 1,    1,    1'b1, 1'b0, 8'h00, 8'h00};
`endif

      // Reset with y held high: reset values, then no count from the held level
      Reset = 1'b1;
      y     = 1'b1;
      Clear = 1'b0;
      tick();
      tick();
      chk("rst_count", 32'(count_bcd), 32'h0000);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_an", 32'(an), 32'(4'b1110));
      chk("rst_seg", 32'(seg), 32'hC0);
      Reset = 1'b0;
      repeat (20) tick();
      chk("held_high_count", 32'(count_bcd), 32'h0000);
      y = 1'b0;
      tick();
      y = 1'b1;
      tick();
      chk("first_edge_count", 32'(count_bcd), 32'h0001);
      y = 1'b0;
      tick();

      // Table-driven pulse runs through the scoreboard
      foreach (vecs[i]) begin
         if (vecs[i].do_reset) reset_dut();
         pulses(vecs[i].pulses);
         exp_q.push_back({vecs[i].exp_ovf, to_bcd(vecs[i].exp_val)});
         check_sb($sformatf("vec%0d", i));
         if (vecs[i].chk_disp) begin
            wait_an(4'b1110, $sformatf("vec%0d_an0", i));
            chk($sformatf("vec%0d_seg0", i), 32'(seg), 32'(vecs[i].exp_seg0));
            wait_an(4'b1101, $sformatf("vec%0d_an1", i));
            chk($sformatf("vec%0d_seg1", i), 32'(seg), 32'(vecs[i].exp_seg1));
         end
      end

      // Clear on its own drops the sticky overflow
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      exp_q.push_back({1'b0, 16'h0000});
      check_sb("clear_only");

      // Clear coincident with a rising edge: the edge is lost
      pulses(42);
      exp_q.push_back({1'b0, 16'h0042});
      check_sb("pre_clear");
      y     = 1'b1;
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      exp_q.push_back({1'b0, 16'h0000});
      check_sb("clear_edge");
      tick();
      chk("clear_keeps_yprev", 32'(count_bcd), 32'h0000);
      y = 1'b0;
      tick();

      // Reset mid-scan at digit 2 abandons count and scan position
      reset_dut();
      pulses(123);
      exp_q.push_back({1'b0, 16'h0123});
      check_sb("pre_midreset");
      wait_an(4'b1011, "midreset_sel2");
      chk("midreset_seg2", 32'(seg), 32'hF9);
      Reset = 1'b1;
      tick();
      chk("midreset_an", 32'(an), 32'(4'b1110));
      chk("midreset_seg", 32'(seg), 32'hC0);
      chk("midreset_count", 32'(count_bcd), 32'h0000);
      Reset = 1'b0;
      measure_hold(4'b1110, "hold_digit0");
      chk("after_hold_an", 32'(an), 32'(4'b1101));
      measure_hold(4'b1101, "hold_digit1");
      chk("after_hold1_an", 32'(an), 32'(4'b1011));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/detect_count_display.md
# detect_count_display

Downstream consumer of the 1100 sequence detector. It counts rising edges of the detector's one-bit `y` output in a DIGITS-wide BCD counter. It drives the count onto a time-multiplexed, active-low 7-segment display using the same 8-bit segment literal format as the detector's `st_literal` (`{dp,g,f,e,d,c,b,a}`, 0 = lit). It sits between the detector and the board's display pins.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits and anodes. Legal range 1..8.
- `REFRESH_DIV`, default 50000: clocks per digit slot. Must be ≥ 2.

Ports:
- `Clock`, in, 1: sole clock; everything is on its rising edge.
- `Reset`, in, 1: reset is synchronous and active-high.
- `y`, in, 1: detector output, synchronous to `Clock`. No synchroniser is needed.
- `Clear`, in, 1: synchronous, active-high; zeroes the count only.
- `count_bcd`, out, 4*DIGITS: registered BCD count. Digit 0 (units) is in bits [3:0].
- `seg`, out, 8: active-low segment literal of the currently selected digit.
- `an`, out, DIGITS: active-low one-hot anode select.
- `overflow`, out, 1: sticky flag, set when the count passes its maximum of DIGITS nines.

## Operation
Edge detection:
- Register `y_prev`.
- An event is `y & ~y_prev` sampled at a clock edge.
- `y_prev <= y` every cycle.

Counter:
- On an event, `count_bcd` increments as BCD. Each digit runs 0..9 and carries to the next digit.
- Any non-BCD nibble is impossible by construction.

Clear:
- `Clear` sets `count_bcd` to 0 and `overflow` to 0.
- `Clear` does not disturb the scan or `y_prev`.
- If `Clear` and an event occur in the same cycle, `Clear` wins and the event is lost.

Display scan:
- `refresh_cnt` counts 0..REFRESH_DIV-1 and wraps.
- On the wrap, `digit_sel` advances 0..DIGITS-1 and wraps to 0.
- `an` is `~(1 << digit_sel)`.
- `seg` is the decode of nibble `digit_sel` of `count_bcd`, with dp forced off (bit7 = 1).
- `seg` and `an` are registered together, so they always change on the same edge.

Decode (active-low):
- 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
- 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90

Reset values:
- `count_bcd` = 0, `overflow` = 0.
- `y_prev` = 1. If `y` is held high through reset release, it does not count.
- `refresh_cnt` = 0, `digit_sel` = 0.
- `an` = all ones except bit0 = 0.
- `seg` = C0.

`Reset` has priority over `Clear`. A mid-operation `Reset` abandons the count and the scan position.

## Timing
- Event latency: `y` rises and is sampled high at edge k while `y_prev` = 0, so `count_bcd` shows the new value after edge k.
- Display latency: the new value reaches `seg` no later than the first edge on which `digit_sel` points at the changed digit.
- Back-to-back events need `y` low for at least one sampled edge between highs. A detector Moore pulse, which lasts at least one cycle, is counted exactly once.
- Each digit is held for exactly REFRESH_DIV clocks. The full frame is DIGITS*REFRESH_DIV clocks.
- Wrap-around (default build): the count goes from all nines to all zeros, and `overflow` is set on that same edge. `overflow` stays set until `Reset` or `Clear`.

## Configuration
Macro `COUNT_SATURATE_EN`:
- Defined: the count holds at all nines. Further events set `overflow` and leave `count_bcd` unchanged.
- Undefined: the count wraps to zero as described in Timing.
- `overflow` behaves identically in both builds.

## Structure
Package `disp_pkg` holds:
- The segment literal constants `SEG_0`..`SEG_9` and `SEG_BLANK` = FF.
- The `DP_OFF` mask.
- A function `bcd_to_seg(logic [3:0]) -> logic [7:0]`. Non-BCD input returns `SEG_BLANK`.

Sub-module `bcd_counter`:
- Parameterised by DIGITS.
- Inputs `Clock`, `Reset`, `Clear`, `inc`. Outputs `count_bcd`, `overflow`.
- Contains the saturate/wrap logic, including the `COUNT_SATURATE_EN` selection.

The top level holds the edge detector, the scan logic and the output registers.

## Test plan
Use `REFRESH_DIV` = 4 and `DIGITS` = 4.
- Reset with `y` held high, release, hold `y` high for 20 cycles → `count_bcd` = 0000. Then `y` low for 1 cycle and high again → 0001.
- Five 1-cycle `y` pulses separated by 1-cycle lows → `count_bcd` = 0005. While `digit_sel` = 0: `seg` = 92, `an` = 1110. While `digit_sel` = 1: `seg` = C0, `an` = 1101.
- Preload to 0009 with 9 pulses, then 1 more pulse → 0010. Units `seg` = C0, tens `seg` = F9.
- Apply 9999 pulses, then 1 more → default build: 0000 with `overflow` = 1. With `COUNT_SATURATE_EN`: 9999 with `overflow` = 1.
- `Clear` asserted in the same cycle as a `y` rising edge with count 0042 → 0000, `overflow` = 0. The edge is not counted.
- Assert `Reset` mid-scan with `digit_sel` = 2 and count 0123 → on the next edge: `an` = 1110, `seg` = C0, `count_bcd` = 0000. `an` changes every 4 clocks after that.
